// File: rtl/servant_pkg.sv
// Shared definitions for the servant RAM arbiter: state encoding and the
// default transaction timeout.
package servant_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_GNT0 = ST_GNT0,
    S_GNT1 = ST_GNT1
  } arb_state_t;

endpackage

// File: rtl/servant_ram_arb.sv
// Two-master round-robin Wishbone arbiter in front of a shared RAM, with a
// per-transaction ack timeout that completes a stuck access with zero data.
module servant_ram_arb
  import servant_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_cyc,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  input  logic [AW-1:0] i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_cyc,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic [AW-1:0] o_wb_s_adr,
  output logic [31:0]   o_wb_s_dat,
  output logic [3:0]    o_wb_s_sel,
  output logic          o_wb_s_we,
  output logic          o_wb_s_cyc,
  input  logic [31:0]   i_wb_s_rdt,
  input  logic          i_wb_s_ack,
  output logic          o_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t    state_reg, state_next;
  logic          last_reg, last_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [AW-1:0] m_adr [2];
  logic [31:0]   m_dat [2];
  logic [3:0]    m_sel [2];
  logic [1:0]    m_we;
  logic [1:0]    m_cyc;
  logic [1:0]    m_ack;

  logic granted;
  logic gnt_idx;
  logic timeout_hit;
  logic resp_ack;
  logic [31:0] resp_rdt;

  assign m_adr[0] = i_wb_m0_adr;
  assign m_adr[1] = i_wb_m1_adr;
  assign m_dat[0] = i_wb_m0_dat;
  assign m_dat[1] = i_wb_m1_dat;
  assign m_sel[0] = i_wb_m0_sel;
  assign m_sel[1] = i_wb_m1_sel;
  assign m_we     = {i_wb_m1_we, i_wb_m0_we};
  assign m_cyc    = {i_wb_m1_cyc, i_wb_m0_cyc};

  assign granted = (state_reg == S_GNT0) || (state_reg == S_GNT1);
  assign gnt_idx = (state_reg == S_GNT1);

  // A real slave ack in the same cycle always beats the timeout.
  assign timeout_hit = granted && m_cyc[gnt_idx] && !i_wb_s_ack &&
                       (cnt_reg == CW'(TIMEOUT));
  assign resp_ack    = granted && (i_wb_s_ack || timeout_hit);
  assign resp_rdt    = timeout_hit ? 32'h0 : i_wb_s_rdt;

  assign o_wb_s_adr = m_adr[gnt_idx];
  assign o_wb_s_dat = m_dat[gnt_idx];
  assign o_wb_s_sel = m_sel[gnt_idx];
  assign o_wb_s_we  = m_we[gnt_idx];
  assign o_wb_s_cyc = granted && m_cyc[gnt_idx] && !timeout_hit;
  assign o_timeout  = timeout_hit;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign m_ack[gi] = resp_ack && (gnt_idx == 1'(gi));
  end

  assign o_wb_m0_ack = m_ack[0];
  assign o_wb_m1_ack = m_ack[1];
  assign o_wb_m0_rdt = resp_rdt;
  assign o_wb_m1_rdt = resp_rdt;

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (m_cyc[0] && m_cyc[1]) begin
          // Contention goes to whoever did not win the last completed grant.
          state_next = last_reg ? S_GNT0 : S_GNT1;
        end else if (m_cyc[0]) begin
          state_next = S_GNT0;
        end else if (m_cyc[1]) begin
          state_next = S_GNT1;
        end
      end
      S_GNT0, S_GNT1: begin
        if (resp_ack) begin
          state_next = S_IDLE;
          last_next  = gnt_idx;
        end else if (!m_cyc[gnt_idx]) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_servant_ram_arb.sv
// Scoreboard bench for servant_ram_arb: a behavioural RAM slave, directed
// master traffic, and an ack monitor that pops expected responses.
module tb_servant_ram_arb;

  typedef struct {
    int          m;
    logic [31:0] rdt;
    bit          tmo;
    bit          cmp_rdt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m1_we, m1_cyc;
  logic [31:0] m0_rdt, m1_rdt;
  logic        m0_ack, m1_ack;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc;
  logic [31:0] slv_rdt;
  logic        slv_ack, stray_ack, s_ack;
  logic        o_tmo;

  logic        slave_mute;
  int          slave_delay;
  int          dly;
  logic [31:0] mem [0:255];

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;

  always #5 clk = ~clk;

  assign s_ack = slv_ack | stray_ack;

  servant_ram_arb #(.AW(32), .TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_m0_adr (m0_adr),
    .i_wb_m0_dat (m0_dat),
    .i_wb_m0_sel (m0_sel),
    .i_wb_m0_we  (m0_we),
    .i_wb_m0_cyc (m0_cyc),
    .o_wb_m0_rdt (m0_rdt),
    .o_wb_m0_ack (m0_ack),
    .i_wb_m1_adr (m1_adr),
    .i_wb_m1_dat (m1_dat),
    .i_wb_m1_sel (m1_sel),
    .i_wb_m1_we  (m1_we),
    .i_wb_m1_cyc (m1_cyc),
    .o_wb_m1_rdt (m1_rdt),
    .o_wb_m1_ack (m1_ack),
    .o_wb_s_adr  (s_adr),
    .o_wb_s_dat  (s_dat),
    .o_wb_s_sel  (s_sel),
    .o_wb_s_we   (s_we),
    .o_wb_s_cyc  (s_cyc),
    .i_wb_s_rdt  (slv_rdt),
    .i_wb_s_ack  (s_ack),
    .o_timeout   (o_tmo)
  );

  // Registered RAM: acks slave_delay cycles after it first sees cyc.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_ack  <= 1'b0;
      slv_rdt  <= 32'h0;
      dly      <= 0;
      mem[64]  <= 32'hDEADBEEF;
    end else begin
      slv_ack <= 1'b0;
      if (s_cyc && !slv_ack && !slave_mute) begin
        if (dly >= slave_delay) begin
          slv_ack <= 1'b1;
          dly     <= 0;
          slv_rdt <= mem[s_adr[9:2]];
          if (s_we) mem[s_adr[9:2]] <= s_dat;
        end else begin
          dly <= dly + 1;
        end
      end else begin
        dly <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic push_exp(input int m, input logic [31:0] rdt, input bit tmo, input bit cmp);
    exp_t e;
    e.m = m; e.rdt = rdt; e.tmo = tmo; e.cmp_rdt = cmp;
    exp_q.push_back(e);
  endtask

  task automatic m_req(input int m, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    if (m == 0) begin
      m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we; m0_cyc = 1'b1;
    end else begin
      m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we; m1_cyc = 1'b1;
    end
  endtask

  task automatic m_rel(input int m);
    if (m == 0) m0_cyc = 1'b0;
    else        m1_cyc = 1'b0;
  endtask

  // Counts cycles from the current one until master m sees ack.
  task automatic wait_ack(input int m, output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      samp();
      if ((m == 0) ? m0_ack : m1_ack) return;
      step();
      cycles++;
    end
    chk($sformatf("ack_wait_m%0d", m), 0, 1);
    cycles = -1;
  endtask

  task automatic do_reset();
    m0_cyc = 1'b0;
    m1_cyc = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ack && m1_ack) chk("dual_ack", 1, 0);
      if (o_tmo && !(m0_ack || m1_ack)) chk("tmo_without_ack", o_tmo, 0);
      if (m0_ack || m1_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {m1_ack, m0_ack}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("[TB] ack m%0d rdt=%08h tmo=%0d", m1_ack ? 1 : 0, m0_rdt, o_tmo);
          chk("sb_master", m1_ack, e.m);
          chk("sb_tmo", o_tmo, e.tmo);
          if (e.cmp_rdt) chk("sb_rdt", {m1_rdt, m0_rdt}, {e.rdt, e.rdt});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0;
    slave_mute = 1'b0; slave_delay = 0; stray_ack = 1'b0;

    repeat (3) step();
    samp();
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_acks", {m1_ack, m0_ack}, 0);
    chk("rst_tmo", o_tmo, 0);
    step();
    rst = 1'b0;

    // Single M0 read with one-cycle RAM.
    m_req(0, 32'h100, 0, 4'hF, 1'b0);
    push_exp(0, 32'hDEADBEEF, 0, 1);
    wait_ack(0, n);
    chk("m0_rd_lat", n, 2);
    step(); m_rel(0);

    // M1 write mirrored to the slave during GNT1 only.
    m_req(1, 32'h40, 32'h12345678, 4'hF, 1'b1);
    push_exp(1, 0, 0, 0);
    samp();
    chk("w_idle_s_cyc", s_cyc, 0);
    step(); samp();
    chk("w_mirror", {s_adr, s_dat, s_sel, s_we, s_cyc}, {32'h40, 32'h12345678, 4'hF, 1'b1, 1'b1});
    chk("w_m0_ack", m0_ack, 0);
    step(); samp();
    chk("w_m1_ack", m1_ack, 1);
    step(); m_rel(1);
    samp();
    chk("w_after_s_cyc", s_cyc, 0);
    step();

    // Read back the written word through M0.
    m_req(0, 32'h40, 0, 4'hF, 1'b0);
    push_exp(0, 32'h12345678, 0, 1);
    wait_ack(0, n);
    chk("m0_readback_lat", n, 2);
    step(); m_rel(0);

    // M0 won last, so contention now goes to M1 first.
    m_req(0, 32'h100, 0, 4'hF, 1'b0);
    m_req(1, 32'h40, 0, 4'hF, 1'b0);
    push_exp(1, 32'h12345678, 0, 1);
    push_exp(0, 32'hDEADBEEF, 0, 1);
    wait_ack(1, n);
    chk("rr_m1_first", n, 2);
    step(); m_rel(1);
    wait_ack(0, n);
    chk("rr_m0_second", n, 2);
    step(); m_rel(0);

    // After reset M0 has priority; alternation continues.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      m_req(0, 32'h100, 0, 4'hF, 1'b0);
      m_req(1, 32'h40, 0, 4'hF, 1'b0);
      push_exp(0, 32'hDEADBEEF, 0, 1);
      push_exp(1, 32'h12345678, 0, 1);
      wait_ack(0, n);
      chk("both_m0_first", n, 2);
      step(); m_rel(0);
      wait_ack(1, n);
      chk("both_m1_after_gap", n, 2);
      step(); m_rel(1);
    end

    // Silent RAM: timeout four cycles after the grant.
    slave_mute = 1'b1;
    m_req(0, 32'h100, 0, 4'hF, 1'b0);
    push_exp(0, 32'h0, 1, 1);
    wait_ack(0, n);
    chk("tmo_lat", n, 5);
    chk("tmo_pulse", o_tmo, 1);
    chk("tmo_s_cyc", s_cyc, 0);
    step(); samp();
    chk("tmo_idle_next", {s_cyc, m0_ack, o_tmo}, 0);
    step(); m_rel(0);
    step();
    slave_mute = 1'b0;

    // RAM ack lands on the timeout cycle: the ack wins.
    slave_delay = 3;
    m_req(0, 32'h100, 0, 4'hF, 1'b0);
    push_exp(0, 32'hDEADBEEF, 0, 1);
    wait_ack(0, n);
    chk("coll_lat", n, 5);
    chk("coll_no_tmo", o_tmo, 0);
    step(); m_rel(0);
    slave_delay = 0;

    // M0 aborts inside GNT0 while M1 waits.
    slave_mute = 1'b1;
    m_req(0, 32'h100, 0, 4'hF, 1'b0);
    samp(); step(); samp();
    chk("ab_gnt0_s_cyc", s_cyc, 1);
    step();
    m_rel(0);
    m_req(1, 32'h40, 0, 4'hF, 1'b0);
    slave_mute = 1'b0;
    samp();
    chk("ab_s_cyc_drop", {s_cyc, m0_ack}, 0);
    push_exp(1, 32'h12345678, 0, 1);
    step();
    wait_ack(1, n);
    chk("ab_m1_lat", n, 2);
    step(); m_rel(1);

    // Stray slave ack while idle is ignored.
    stray_ack = 1'b1;
    samp();
    chk("stray_acks", {m1_ack, m0_ack}, 0);
    step();
    stray_ack = 1'b0;

    // Reset in the middle of GNT1 abandons the transaction at once.
    slave_mute = 1'b1;
    m_req(1, 32'h40, 0, 4'hF, 1'b0);
    samp(); step(); samp();
    chk("rs_gnt1_s_cyc", s_cyc, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_async", {m1_ack, m0_ack, s_cyc, o_tmo}, 0);
    step();
    m_rel(1);
    slave_mute = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      samp();
      chk("rs_no_ack", {m1_ack, m0_ack, s_cyc}, 0);
      step();
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
